// File: rtl/uart_wb_host.sv
// UART command frames in, single 32-bit Wishbone master cycles out.
// Define UART_WB_HOST_CHECKSUM_EN for the trailing XOR byte in both directions.
module uart_wb_host #(
   parameter int CLK_DIV = 868,
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy_o,
   output logic        err_o
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] C_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_MID = CW'(CLK_DIV / 2 - 1);
   localparam logic [7:0] TMO_END = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RESP
   } state_t;
`ifdef UART_WB_HOST_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM;
   localparam logic [2:0] RD_N = 3'd5;
`else
   localparam state_t S_TAIL = S_BUS;
   localparam logic [2:0] RD_N = 3'd4;
`endif

   logic [1:0]    r_sync;
   logic          w_rx;
   logic          r_rx_act;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic          r_rx_vld;
   logic          r_rx_ferr;

   assign w_rx = r_sync[1];

   // bit 0 is the start bit (checked at half period), 1-8 data, 9 stop
   always_ff @(posedge wb_clk_i) begin
      r_sync    <= {r_sync[0], uart_rx_i};
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (wb_rst_i) begin
         r_sync   <= 2'b11;
         r_rx_act <= 1'b0;
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
         r_rx_sh  <= '0;
      end else if (!r_rx_act) begin
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
         r_rx_act <= ~w_rx;
      end else if (r_rx_bit == 4'd0) begin
         if (r_rx_cnt == C_MID) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 4'd1;
            r_rx_act <= ~w_rx;
         end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
         end
      end else if (r_rx_cnt == C_END) begin
         r_rx_cnt <= '0;
         r_rx_bit <= r_rx_bit + 4'd1;
         if (r_rx_bit == 4'd9) begin
            r_rx_act  <= 1'b0;
            r_rx_vld  <= w_rx;
            r_rx_ferr <= ~w_rx;
         end else begin
            r_rx_sh <= {w_rx, r_rx_sh[7:1]};
         end
      end else begin
         r_rx_cnt <= r_rx_cnt + 1'b1;
      end
   end

   state_t        r_state;
   state_t        w_nxt;
   logic [1:0]    r_bcnt;
   logic          r_we;
   logic [7:0]    r_tmo;
   logic          w_err;
   logic          w_tx_go;
   logic [47:0]   w_tx_buf;
   logic [2:0]    w_tx_n;
   logic          w_tx_done;
   logic [7:0]    w_rsum;
`ifdef UART_WB_HOST_CHECKSUM_EN
   logic [7:0]    r_csum;
`endif

   logic          r_tx_act;
   logic [CW-1:0] r_tx_cnt;
   logic [3:0]    r_tx_bit;
   logic [9:0]    r_tx_frm;
   logic [39:0]   r_tx_buf;
   logic [2:0]    r_tx_left;

   assign uart_tx_o = r_tx_frm[0];
   assign w_tx_done = r_tx_act && r_tx_cnt == C_END &&
                      r_tx_bit == 4'd9 && r_tx_left == 3'd0;

   // queued bytes follow the previous stop bit with no idle gap
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_tx_act  <= 1'b0;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_frm  <= '1;
         r_tx_buf  <= '0;
         r_tx_left <= '0;
      end else if (w_tx_go) begin
         r_tx_act  <= 1'b1;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_frm  <= {1'b1, w_tx_buf[47:40], 1'b0};
         r_tx_buf  <= w_tx_buf[39:0];
         r_tx_left <= w_tx_n;
      end else if (r_tx_act) begin
         if (r_tx_cnt != C_END) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
         end else begin
            r_tx_cnt <= '0;
            if (r_tx_bit != 4'd9) begin
               r_tx_frm <= {1'b1, r_tx_frm[9:1]};
               r_tx_bit <= r_tx_bit + 4'd1;
            end else if (r_tx_left == 3'd0) begin
               r_tx_act <= 1'b0;
            end else begin
               r_tx_frm  <= {1'b1, r_tx_buf[39:32], 1'b0};
               r_tx_buf  <= {r_tx_buf[31:0], 8'h00};
               r_tx_left <= r_tx_left - 3'd1;
               r_tx_bit  <= '0;
            end
         end
      end
   end

   assign w_rsum = 8'h06 ^ wbm_dat_i[31:24] ^ wbm_dat_i[23:16] ^
                   wbm_dat_i[15:8] ^ wbm_dat_i[7:0];

   always_comb begin
      w_nxt    = r_state;
      w_err    = 1'b0;
      w_tx_go  = 1'b0;
      w_tx_buf = {8'h15, 40'h0};
      w_tx_n   = 3'd0;
      unique case (r_state)
         S_IDLE: if (r_rx_vld) begin
            if (r_rx_sh == 8'h57 || r_rx_sh == 8'h52) w_nxt = S_ADDR;
            else w_err = 1'b1;
         end
         S_ADDR: if (r_rx_vld && r_bcnt == 2'd3)
            w_nxt = r_we ? S_DATA : S_TAIL;
         S_DATA: if (r_rx_vld && r_bcnt == 2'd3) w_nxt = S_TAIL;
`ifdef UART_WB_HOST_CHECKSUM_EN
         S_CSUM: if (r_rx_vld) begin
            if (r_rx_sh == r_csum) begin
               w_nxt = S_BUS;
            end else begin
               w_err   = 1'b1;
               w_tx_go = 1'b1;
               w_nxt   = S_RESP;
            end
         end
`endif
         S_BUS: if (wbm_ack_i) begin
            w_tx_go = 1'b1;
            w_nxt   = S_RESP;
            if (r_we) begin
               w_tx_buf = {8'h06, 40'h0};
            end else begin
               w_tx_buf = {8'h06, wbm_dat_i, w_rsum};
               w_tx_n   = RD_N;
            end
         end else if (r_tmo == TMO_END) begin
            w_err   = 1'b1;
            w_tx_go = 1'b1;
            w_nxt   = S_RESP;
         end
         S_RESP: if (w_tx_done) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      if (r_rx_ferr && r_state != S_BUS && r_state != S_RESP) begin
         w_err = 1'b1;
         w_nxt = S_IDLE;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= S_IDLE;
         r_bcnt    <= '0;
         r_we      <= 1'b0;
         r_tmo     <= '0;
         err_o     <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
`ifdef UART_WB_HOST_CHECKSUM_EN
         r_csum    <= '0;
`endif
      end else begin
         r_state <= w_nxt;
         err_o   <= w_err;
         r_tmo   <= (r_state == S_BUS) ? r_tmo + 8'd1 : 8'd0;
         if (r_rx_vld && r_state == S_IDLE) begin
            r_we   <= (r_rx_sh == 8'h57);
            r_bcnt <= '0;
         end
         if (r_rx_vld && r_state == S_ADDR) begin
            wbm_adr_o <= {wbm_adr_o[23:0], r_rx_sh};
            r_bcnt    <= r_bcnt + 2'd1;
         end
         if (r_rx_vld && r_state == S_DATA) begin
            wbm_dat_o <= {wbm_dat_o[23:0], r_rx_sh};
            r_bcnt    <= r_bcnt + 2'd1;
         end
`ifdef UART_WB_HOST_CHECKSUM_EN
         if (r_rx_vld)
            r_csum <= (r_state == S_IDLE) ? r_rx_sh : r_csum ^ r_rx_sh;
`endif
      end
   end

   assign wbm_cyc_o = (r_state == S_BUS);
   assign wbm_stb_o = wbm_cyc_o;
   assign wbm_we_o  = wbm_cyc_o & r_we;
   assign wbm_sel_o = {4{wbm_cyc_o}};
   assign busy_o    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_wb_host.sv
// Scoreboard bench for uart_wb_host: expected bus cycles and TX bytes
// are queued by the stimulus and popped by independent monitors.
module tb_uart_wb_host;
   localparam int CLK_DIV = 16;
   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        tx, cyc, stb, we, ack, busy, err;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;

   always #5 clk = ~clk;

   uart_wb_host #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .uart_rx_i(rx),
      .uart_tx_o(tx),
      .wbm_cyc_o(cyc),
      .wbm_stb_o(stb),
      .wbm_we_o (we),
      .wbm_sel_o(sel),
      .wbm_adr_o(adr),
      .wbm_dat_o(dat_o),
      .wbm_dat_i(dat_i),
      .wbm_ack_i(ack),
      .busy_o   (busy),
      .err_o    (err)
   );

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      int          n;
   } bus_t;
   typedef struct {
      logic [7:0] b;
      bit         b2b;
   } txe_t;

   int checks = 0;
   int errors = 0;
   int ack_lat = 0;
   int stb_n = 0;
   int cyc_n = 0;
   int err_n = 0;
   logic [31:0] rdata = 32'h0;
   bus_t busq[$];
   txe_t txq[$];
   logic [7:0] fq[$];

   // slave model: ack after ack_lat wait cycles, never if negative
   assign ack = stb && (ack_lat >= 0) && (stb_n == ack_lat);
   assign dat_i = rdata;

   always @(posedge clk) begin
      cyc_n++;
      stb_n <= stb ? stb_n + 1 : 0;
   end

   always @(negedge clk) if (err === 1'b1) err_n++;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   initial begin : bus_mon
      bus_t e;
      logic we0;
      logic [31:0] a0, d0;
      logic [3:0] s0;
      int n;
      bit stab;
      forever begin
         @(negedge clk);
         if (cyc === 1'b1) begin
            we0 = we; a0 = adr; d0 = dat_o; s0 = sel;
            n = 0; stab = 1'b1;
            while (cyc === 1'b1) begin
               n++;
               if (stb !== 1'b1 || we !== we0 || adr !== a0 ||
                   dat_o !== d0 || sel !== s0) stab = 1'b0;
               @(negedge clk);
            end
            if (busq.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_unexpected: cycle at adr %0h, none expected",
                        a0);
            end else begin
               e = busq.pop_front();
               chk("bus_stable", 64'(stab), 64'd1);
               chk("bus_sel", 64'(s0), 64'hF);
               chk("bus_we", 64'(we0), 64'(e.we));
               chk("bus_adr", 64'(a0), 64'(e.adr));
               if (e.we) chk("bus_dat", 64'(d0), 64'(e.dat));
               if (e.n > 0) chk("bus_len", 64'(n), 64'(e.n));
            end
         end
      end
   end

   initial begin : tx_mon
      logic [7:0] b;
      int t0, tlast;
      bit ok;
      txe_t e;
      tlast = -100000;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            t0 = cyc_n;
            repeat (CLK_DIV / 2) @(negedge clk);
            ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CLK_DIV) @(negedge clk);
               b[i] = tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            ok = ok && (tx === 1'b1);
            if (txq.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_unexpected: byte %0h, none expected", b);
            end else begin
               e = txq.pop_front();
               chk("tx_frame", 64'(ok), 64'd1);
               chk("tx_byte", 64'(b), 64'(e.b));
               if (e.b2b) chk("tx_gap", 64'(t0 - tlast), 64'(10 * CLK_DIV));
            end
            tlast = t0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      if (stop_ok) begin
         rx = 1'b1;
         repeat (CLK_DIV) @(negedge clk);
      end else begin
         rx = 1'b0;
         repeat (12) @(negedge clk);
         rx = 1'b1;
         repeat (CLK_DIV + 16) @(negedge clk);
      end
   endtask

   task automatic send_frame();
      logic [7:0] x = 8'h00;
      foreach (fq[i]) begin
         x ^= fq[i];
         send_byte(fq[i]);
      end
`ifdef UART_WB_HOST_CHECKSUM_EN
      send_byte(x);
`endif
      fq.delete();
   endtask

   task automatic exp_write(input logic [31:0] a, input logic [31:0] d,
                            input int n);
      busq.push_back(bus_t'{1'b1, a, d, n});
      txq.push_back(txe_t'{8'h06, 1'b0});
   endtask

   task automatic exp_read(input logic [31:0] a, input logic [31:0] d);
      logic [7:0] x = 8'h06;
      busq.push_back(bus_t'{1'b0, a, 32'h0, 1});
      txq.push_back(txe_t'{8'h06, 1'b0});
      for (int i = 3; i >= 0; i--) begin
         txq.push_back(txe_t'{d[8*i +: 8], 1'b1});
         x ^= d[8*i +: 8];
      end
`ifdef UART_WB_HOST_CHECKSUM_EN
      txq.push_back(txe_t'{x, 1'b1});
`endif
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while ((busy !== 1'b0 || txq.size() != 0 || busq.size() != 0) &&
             t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_done"}, 64'(t < 5000), 64'd1);
      repeat (20) @(negedge clk);
   endtask

   initial begin : stim
      int e0, t;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cyc", 64'(cyc), 64'd0);
      chk("rst_stb", 64'(stb), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_sel", 64'(sel), 64'd0);
      chk("rst_adr", 64'(adr), 64'd0);
      chk("rst_dat", 64'(dat_o), 64'd0);
      chk("rst_tx", 64'(tx), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      ack_lat = 1; e0 = err_n;
      exp_write(32'h10, 32'hDEADBEEF, 2);
      fq = {8'h57, 8'h00, 8'h00, 8'h00, 8'h10,
            8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame();
      wait_done("wr");
      chk("wr_err", 64'(err_n - e0), 64'd0);

      ack_lat = 0; rdata = 32'h12345678; e0 = err_n;
      exp_read(32'h4, 32'h12345678);
      fq = {8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
      send_frame();
      wait_done("rd");
      chk("rd_err", 64'(err_n - e0), 64'd0);

      ack_lat = -1; e0 = err_n;
      busq.push_back(bus_t'{1'b0, 32'h20, 32'h0, TIMEOUT});
      txq.push_back(txe_t'{8'h15, 1'b0});
      fq = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      send_frame();
      wait_done("tmo");
      chk("tmo_err", 64'(err_n - e0), 64'd1);

      ack_lat = 0; e0 = err_n;
      send_byte(8'h41);
      exp_write(32'h8, 32'h01020304, 1);
      fq = {8'h57, 8'h00, 8'h00, 8'h00, 8'h08,
            8'h01, 8'h02, 8'h03, 8'h04};
      send_frame();
      wait_done("badcmd");
      chk("badcmd_err", 64'(err_n - e0), 64'd1);

      rdata = 32'hA5A50F0F; e0 = err_n;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00, 1'b0);
      exp_read(32'h4, 32'hA5A50F0F);
      fq = {8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
      send_frame();
      wait_done("ferr");
      chk("ferr_err", 64'(err_n - e0), 64'd1);

      ack_lat = -1; e0 = err_n;
      busq.push_back(bus_t'{1'b0, 32'h30, 32'h0, 0});
      fq = {8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
      send_frame();
      t = 0;
      while (cyc !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("rst_cyc_up", 64'(cyc), 64'd1);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_cyc", 64'(cyc), 64'd0);
      chk("midrst_stb", 64'(stb), 64'd0);
      chk("midrst_tx", 64'(tx), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      chk("midrst_busq", 64'(busq.size()), 64'd0);
      chk("midrst_err", 64'(err_n - e0), 64'd0);
      ack_lat = 0; rdata = 32'hCAFEF00D;
      exp_read(32'h4, 32'hCAFEF00D);
      fq = {8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
      send_frame();
      wait_done("postrst");

`ifdef UART_WB_HOST_CHECKSUM_EN
      e0 = err_n;
      txq.push_back(txe_t'{8'h15, 1'b0});
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h00);
      wait_done("csum");
      chk("csum_err", 64'(err_n - e0), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
